// File: rtl/alu_seq_ctrl.sv
// Multi-byte arithmetic sequencer: drives an 8-bit flag-holding ALU one byte per
// clock, LSB first, chaining carry/borrow through the ALU's own carry flag.
module alu_seq_ctrl #(
    parameter int NBYTES = 2,
    localparam int W = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         zero,
    output logic [7:0]   scrA,
    output logic [7:0]   scrB,
    output logic [2:0]   alucs,
    output logic         flagwrite,
    input  logic [7:0]   s
);

    localparam int IW = (NBYTES > 2) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                  state;
    logic [IW-1:0]           idx;
    logic [IW-1:0]           idx_nx;
    logic [NBYTES-1:0][7:0]  a_q;
    logic [NBYTES-1:0][7:0]  b_q;
    logic [NBYTES-1:0][7:0]  res_q;
    logic [1:0]              op_q;
    logic                    zero_acc;

    assign idx_nx = idx + 1'b1;
    assign result = res_q;
    assign zero   = zero_acc;

    // Upper bytes of ADD/SUB switch to the carry-consuming opcodes.
    function automatic logic [2:0] hi_code(input logic [1:0] o);
        case (o)
            2'b10:   return 3'b110;
            2'b11:   return 3'b101;
            default: return {1'b0, o};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 2'b00;
            res_q     <= '0;
            zero_acc  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            scrA      <= 8'h00;
            scrB      <= 8'h00;
            alucs     <= 3'b000;
            flagwrite <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q       <= a;
                        b_q       <= b;
                        op_q      <= op;
                        idx       <= '0;
                        zero_acc  <= 1'b1;
                        state     <= RUN;
                        busy      <= 1'b1;
                        scrA      <= a[7:0];
                        scrB      <= b[7:0];
                        alucs     <= {1'b0, op};
                        flagwrite <= op[1];
                    end
                end
                RUN: begin
                    res_q[idx] <= s;
                    zero_acc   <= zero_acc & (s == 8'h00);
                    if (idx == LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        scrA      <= 8'h00;
                        scrB      <= 8'h00;
                        alucs     <= 3'b000;
                        flagwrite <= 1'b0;
                    end else begin
                        // ALU inputs for the next byte are set up here so they
                        // are stable for the whole next cycle.
                        idx   <= idx_nx;
                        scrA  <= a_q[idx_nx];
                        scrB  <= b_q[idx_nx];
                        alucs <= hi_code(op_q);
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl with a behavioural 8-bit flag-holding ALU and a
// result scoreboard popped on each done pulse.
module tb_alu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] a, b;
    logic        busy, done, zero, flagwrite;
    logic [15:0] result;
    logic [7:0]  scrA, scrB, s;
    logic [2:0]  alucs;

    int n_cmp  = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [16:0] sb[$];

    always #5 clk = ~clk;

    alu_seq_ctrl #(.NBYTES(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .zero(zero),
        .scrA(scrA), .scrB(scrB), .alucs(alucs), .flagwrite(flagwrite), .s(s)
    );

    // Behavioural ALU: carry flag holds carry-out for ADD, borrow for SUB.
    logic       carry = 1'b0;
    logic [8:0] alu_full;
    always_comb begin
        alu_full = 9'h000;
        case (alucs)
            3'b000: alu_full = {1'b0, scrA & scrB};
            3'b001: alu_full = {1'b0, scrA | scrB};
            3'b010: alu_full = {1'b0, scrA} + {1'b0, scrB};
            3'b110: alu_full = {1'b0, scrA} + {1'b0, scrB} + {8'h00, carry};
            3'b011: alu_full = {1'b0, scrA} - {1'b0, scrB};
            3'b101: alu_full = {1'b0, scrA} - {1'b0, scrB} - {8'h00, carry};
            default: alu_full = 9'h000;
        endcase
    end
    assign s = alu_full[7:0];
    always @(posedge clk) if (flagwrite) carry <= alu_full[8];

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            logic [16:0] e;
            done_cnt++;
            n_cmp++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: result=%h zero=%b, no operation pending", result, zero);
            end else begin
                e = sb.pop_front();
                if ({result, zero} !== e) begin
                    n_fail++;
                    $display("FAIL done_result: got result=%h zero=%b, want result=%h zero=%b",
                             result, zero, e[16:1], e[0]);
                end
            end
        end
    end

    function automatic logic [15:0] model(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
        case (o)
            2'b00:   return x & y;
            2'b01:   return x | y;
            2'b10:   return x + y;
            default: return x - y;
        endcase
    endfunction

    function automatic logic [2:0] hi_exp(input logic [1:0] o);
        if (o == 2'b10) return 3'b110;
        if (o == 2'b11) return 3'b101;
        return {1'b0, o};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // One full operation; optionally pokes a competing start during RUN.
    task automatic run_op(input logic [1:0] o, input logic [15:0] xa, input logic [15:0] xb,
                          input bit poke);
        logic [15:0] e;
        int d0;
        e = model(o, xa, xb);
        sb.push_back({e, e == 16'h0000});
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; op = o; a = xa; b = xb;
        @(negedge clk);                       // RUN byte 0
        start = 1'b0;
        if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL byte0_busy: busy=%b done=%b want 1/0", busy, done); end
        n_cmp++;
        if (alucs !== {1'b0, o}) begin n_fail++; $display("FAIL byte0_alucs: got %b want %b", alucs, {1'b0, o}); end
        n_cmp++;
        if (flagwrite !== o[1]) begin n_fail++; $display("FAIL byte0_flagwrite: got %b want %b", flagwrite, o[1]); end
        n_cmp++;
        if ({scrA, scrB} !== {xa[7:0], xb[7:0]}) begin n_fail++; $display("FAIL byte0_operands: got %h/%h want %h/%h", scrA, scrB, xa[7:0], xb[7:0]); end
        n_cmp++;
        if (poke) begin
            start = 1'b1; op = ~o; a = 16'hA5A5; b = 16'h5A5A;
        end
        @(negedge clk);                       // RUN byte 1
        start = 1'b0;
        if (alucs !== hi_exp(o)) begin n_fail++; $display("FAIL byte1_alucs: got %b want %b", alucs, hi_exp(o)); end
        n_cmp++;
        if (flagwrite !== o[1] || busy !== 1'b1) begin n_fail++; $display("FAIL byte1_ctrl: flagwrite=%b busy=%b want %b/1", flagwrite, busy, o[1]); end
        n_cmp++;
        if ({scrA, scrB} !== {xa[15:8], xb[15:8]}) begin n_fail++; $display("FAIL byte1_operands: got %h/%h want %h/%h", scrA, scrB, xa[15:8], xb[15:8]); end
        n_cmp++;
        @(negedge clk);                       // DONE at k+3
        if (done !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL done_timing: done=%b busy=%b want 1/0", done, busy); end
        n_cmp++;
        if ({scrA, scrB, alucs, flagwrite} !== 20'h0) begin n_fail++; $display("FAIL done_alu_idle: scrA=%h scrB=%h alucs=%b fw=%b want zeros", scrA, scrB, alucs, flagwrite); end
        n_cmp++;
        @(negedge clk);                       // back in IDLE
        if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_after: done=%b busy=%b want 0/0", done, busy); end
        n_cmp++;
        chk("done_count", 32'(done_cnt - d0), 32'd1);
        chk("held_result", {15'h0, result, zero}, {15'h0, e, e == 16'h0000});
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 2'b00; a = 16'h0; b = 16'h0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {8'h0, busy, done, zero, flagwrite, alucs, 1'b0, result},
                             32'h0);
        chk("reset_operands", {16'h0, scrA, scrB}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_no_start", {29'h0, busy, done, flagwrite}, 32'h0);
    endtask

    task automatic test_add();
        run_op(2'b10, 16'h00FF, 16'h0001, 1'b0);
    endtask

    task automatic test_sub();
        run_op(2'b11, 16'h0100, 16'h0001, 1'b0);
        run_op(2'b11, 16'h1234, 16'h1234, 1'b0);
    endtask

    task automatic test_logic();
        run_op(2'b00, 16'hF0F0, 16'h0FF0, 1'b0);
        run_op(2'b01, 16'h0006, 16'h0005, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_op(2'b10, 16'h1111, 16'h2222, 1'b1);
    endtask

    task automatic test_mid_reset();
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 16'h4321; b = 16'h1234;
        @(negedge clk);                       // RUN byte 0
        start = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_state", {12'h0, busy, done, flagwrite, alucs, scrA, scrB, 1'b0},
                              32'h0);
        chk("midreset_result", {15'h0, result, zero}, 32'h0);
        repeat (4) @(negedge clk);
        chk("midreset_no_done", {31'h0, busy}, 32'h0);
        run_op(2'b10, 16'hFFFF, 16'h0001, 1'b0);
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < 3; i++) sb.push_back({16'h0406, 1'b0});
        @(negedge clk);
        start = 1'b1; op = 2'b10; a = 16'h0102; b = 16'h0304;
        for (int n = 1; n <= 13; n++) begin
            @(negedge clk);
            chk("b2b_done_slot", {31'h0, done}, {31'h0, (n == 3 || n == 7 || n == 11)});
            chk("b2b_busy_excl", {31'h0, busy & done}, 32'h0);
            if (n == 10) start = 1'b0;
        end
        chk("b2b_done_count", 32'(done_cnt - d0), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_ignore_start();
        test_mid_reset();
        test_back_to_back();
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-byte arithmetic sequencer that drives the team's 8-bit flag-holding ALU (scrA/scrB/alucs/flagwrite in, s out) to perform NBYTES-wide operations one byte per clock, least-significant byte first. For ADD/SUB it uses the ALU's carry-chained opcodes (ADDC/SUBC) on the upper bytes, relying on the ALU's internal carry flag latched on clk. The block sits between the datapath control and the ALU.

## Interface
- NBYTES, 2, operand width in bytes (≥2); W = 8*NBYTES
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only in IDLE
- op  in  2  00 AND, 01 OR, 10 ADD, 11 SUB
- a  in  W  operand A; captured on accepted start
- b  in  W  operand B; captured on accepted start
- busy  out  1  high from the cycle after acceptance through the last byte cycle
- done  out  1  one-cycle pulse; result/zero valid in that cycle
- result  out  W  assembled result; held until the next accepted start
- zero  out  1  1 when the full W-bit result is 0; held like result
- scrA  out  8  ALU operand A byte
- scrB  out  8  ALU operand B byte
- alucs  out  3  ALU opcode: AND 000, OR 001, ADD 010, SUB 011, SUBC 101, ADDC 110
- flagwrite  out  1  ALU flag-register write enable
- s  in  8  ALU result byte, combinational from scrA/scrB/alucs/carry flag

## Operation
- States: IDLE, RUN, DONE. Byte index idx is 0..NBYTES-1.
- IDLE: scrA=scrB=0, alucs=000, flagwrite=0. On start=1, a/b/op are registered, idx clears to 0, and the state goes to RUN. Start is ignored in every other state.
- RUN, byte idx: scrA=a[8*idx+:8] and scrB=b[8*idx+:8], taken from the registered copy.
- alucs in RUN:
  - idx=0: the op's base code (AND 000, OR 001, ADD 010, SUB 011).
  - idx>0: ADD uses ADDC (110), SUB uses SUBC (101), AND/OR reuse the base code.
- flagwrite=1 in RUN for ADD/SUB. flagwrite=0 in RUN for AND/OR, so the ALU carry is not disturbed.
- Each RUN edge: s is written into result[8*idx+:8], and the zero accumulator is ANDed with (s==0). The accumulator is set to 1 on acceptance.
- After the edge with idx=NBYTES-1, the state goes to DONE. Otherwise idx increments.
- DONE: done=1 and the ALU outputs return to idle values. Next edge goes to IDLE.
- SUB semantics follow the ALU: result = a − b mod 2^W (borrow chained through SUBC). Carry-out is not exported.
- Reset: state=IDLE, idx=0, busy=0, done=0, result=0, zero=0, scrA=scrB=0, alucs=000, flagwrite=0. Reset during RUN or DONE aborts the operation with no done pulse; result returns to 0.
- rst and start together: rst wins.

## Timing
- Start sampled at edge k. RUN byte 0 occupies cycle k+1 … byte NBYTES-1 occupies cycle k+NBYTES. DONE (done=1) is cycle k+NBYTES+1. IDLE returns at k+NBYTES+2.
- Latency from accepted start to done is NBYTES+1 cycles. Throughput is one operation per NBYTES+2 cycles.
- busy=1 exactly in RUN cycles and DONE is excluded, so busy=0 whenever done=1.
- All ALU-side outputs are registered (or decoded from registered state) and stable for the whole cycle. This lets the ALU carry flag update at the end of byte i and feed ADDC/SUBC in byte i+1.
- A start held high continuously is accepted again on the first IDLE cycle after DONE.

## Test plan
Bench instantiates the existing 8-bit ALU with NBYTES=2.
- ADD 0x00FF + 0x0001 → alucs sequence 010, 110; done at k+3; result=0x0100, zero=0.
- SUB 0x0100 − 0x0001 → alucs 011, 101; result=0x00FF. Then SUB 0x1234 − 0x1234 → result=0x0000, zero=1.
- AND 0xF0F0 & 0x0FF0 → result=0x00F0, flagwrite=0 every cycle. Then OR 0x0006 | 0x0005 → result=0x0007, zero=0.
- Start pulsed again during RUN with a different op → ignored; first result is unchanged and only one done pulse occurs.
- rst asserted in the cycle after acceptance (mid-RUN) → next cycle shows IDLE values, result=0, zero=0, no done. A fresh ADD 0xFFFF + 0x0001 then gives result=0x0000, zero=1.
- start held high for 10 cycles → done pulses every 4 cycles, and busy is never high together with done.
